// File: rtl/corevx_cache_pkg.sv
// corevx_cache_pkg: cache command/response encodings, grant owner codes and arbiter state
// shared by the cache arbiter slice.
package corevx_cache_pkg;

    localparam logic [3:0] CMD_NONE      = 4'd0;
    localparam logic [3:0] CMD_LOAD      = 4'd1;
    localparam logic [3:0] CMD_STORE     = 4'd2;
    localparam logic [3:0] CMD_EXECUTE   = 4'd3;
    localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

    localparam logic [3:0] RSP_IDLE        = 4'd0;
    localparam logic [3:0] RSP_WAIT        = 4'd1;
    localparam logic [3:0] RSP_DONE        = 4'd2;
    localparam logic [3:0] RSP_ACCESSFAULT = 4'd3;
    localparam logic [3:0] RSP_MISSALIGNED = 4'd4;
    localparam logic [3:0] RSP_PAGEFAULT   = 4'd5;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DATA
    } arb_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] address;
        logic [2:0]  load_type;
        logic [1:0]  store_type;
        logic [31:0] store_data;
    } cache_req_t;

    function automatic logic is_terminal(input logic [3:0] rsp);
        return rsp == RSP_DONE || rsp == RSP_ACCESSFAULT || rsp == RSP_MISSALIGNED || rsp == RSP_PAGEFAULT;
    endfunction

endpackage

// File: rtl/corevx_cache_arbiter_if.sv
// corevx_cache_arbiter_if: one cache request/response port; master issues commands, slave answers.
interface corevx_cache_arbiter_if;

    logic [3:0]  cmd;
    logic [31:0] address;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] store_data;
    logic [3:0]  response;
    logic [31:0] load_data;
    logic        reset_done;

    modport master (
        output cmd, address, load_type, store_type, store_data,
        input  response, load_data, reset_done
    );

    modport slave (
        input  cmd, address, load_type, store_type, store_data,
        output response, load_data, reset_done
    );

endinterface

// File: rtl/corevx_cache_arb_rr.sv
// corevx_cache_arb_rr: 2-way winner picker; fixed DATA priority, or round-robin on ties
// when COREVX_CACHE_ARB_ROUNDROBIN_EN is defined.
module corevx_cache_arb_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic f_req,
    input  logic d_req,
    input  logic grant,
    output logic pick_f,
    output logic pick_d
);

`ifdef COREVX_CACHE_ARB_ROUNDROBIN_EN
    logic last_fetch;

    // reset as if fetch was served last so data wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_fetch <= 1'b1;
        else if (grant)
            last_fetch <= pick_f;
    end

    assign pick_d = d_req && !(f_req && !last_fetch);
`else
    logic unused_rr;

    assign unused_rr = &{1'b0, clk, rst_n, grant};
    assign pick_d    = d_req;
`endif

    assign pick_f = f_req && !pick_d;

endmodule

// File: rtl/corevx_cache_arbiter.sv
// corevx_cache_arbiter: shares one cache port between fetch and data with a zero-cycle grant.
// Tie-break is fixed DATA priority unless COREVX_CACHE_ARB_ROUNDROBIN_EN is defined.
module corevx_cache_arbiter
    import corevx_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    corevx_cache_arbiter_if.slave  f_bus,
    corevx_cache_arbiter_if.slave  d_bus,
    corevx_cache_arbiter_if.master c_bus,
    output logic [1:0]             grant_owner
);

    arb_state_e state;
    cache_req_t f_pkt, d_pkt;
    logic       active, term, arb, f_req, d_req, pick_f, pick_d, f_own, d_own;
    logic [1:0] drv;

    assign active = rst_n && c_bus.reset_done;
    assign term   = state != ARB_IDLE && is_terminal(c_bus.response);
    assign arb    = active && (state == ARB_IDLE || term);
    // the finishing owner is not a candidate in its own terminal cycle
    assign f_req  = f_bus.cmd != CMD_NONE && !(term && state == ARB_FETCH);
    assign d_req  = d_bus.cmd != CMD_NONE && !(term && state == ARB_DATA);

    corevx_cache_arb_rr u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .f_req  (f_req),
        .d_req  (d_req),
        .grant  (arb && (f_req || d_req)),
        .pick_f (pick_f),
        .pick_d (pick_d)
    );

    assign drv = !active ? OWN_NONE :
                 !arb    ? (state == ARB_DATA ? OWN_DATA : OWN_FETCH) :
                 pick_d  ? OWN_DATA : pick_f ? OWN_FETCH : OWN_NONE;

    assign f_pkt = {f_bus.cmd, f_bus.address, f_bus.load_type, f_bus.store_type, f_bus.store_data};
    assign d_pkt = {d_bus.cmd, d_bus.address, d_bus.load_type, d_bus.store_type, d_bus.store_data};
    assign {c_bus.cmd, c_bus.address, c_bus.load_type, c_bus.store_type, c_bus.store_data} =
        drv == OWN_DATA ? d_pkt : drv == OWN_FETCH ? f_pkt : '0;

    assign f_own = active && state == ARB_FETCH;
    assign d_own = active && state == ARB_DATA;

    assign f_bus.response   = f_own ? c_bus.response : (active && f_bus.cmd != CMD_NONE) ? RSP_WAIT : RSP_IDLE;
    assign d_bus.response   = d_own ? c_bus.response : (active && d_bus.cmd != CMD_NONE) ? RSP_WAIT : RSP_IDLE;
    assign f_bus.load_data  = f_own ? c_bus.load_data : '0;
    assign d_bus.load_data  = d_own ? c_bus.load_data : '0;
    assign f_bus.reset_done = c_bus.reset_done;
    assign d_bus.reset_done = c_bus.reset_done;

    always_ff @(posedge clk) begin
        if (!active) begin
            state       <= ARB_IDLE;
            grant_owner <= OWN_NONE;
        end else if (arb) begin
            state       <= pick_d ? ARB_DATA : pick_f ? ARB_FETCH : ARB_IDLE;
            grant_owner <= pick_d ? OWN_DATA : pick_f ? OWN_FETCH : OWN_NONE;
        end
    end

endmodule

// File: doc/corevx_cache_arbiter.md
COREVX_CACHE_ARBITER -- requirements
Module: corevx_cache_arbiter

Interface
REQ-001 Module SHALL have no parameters; cmd/response encodings come from corevx_cache_pkg.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 f_cmd  in  4  fetch request (NONE/EXECUTE/FLUSH_ALL).
REQ-005 f_address  in  32  fetch address.
REQ-006 f_response  out  4  response routed to fetch.
REQ-007 f_load_data  out  32  instruction data to fetch.
REQ-008 d_cmd  in  4  data request (NONE/LOAD/STORE/FLUSH_ALL).
REQ-009 d_address  in  32  data address.
REQ-010 d_load_type  in  3  load type; d_store_type  in  2  store type; d_store_data  in  32  store data.
REQ-011 d_response  out  4  response routed to data port; d_load_data  out  32  load data.
REQ-012 c_cmd  out  4; c_address  out  32; c_load_type  out  3; c_store_type  out  2; c_store_data  out  32  shared cache port.
REQ-013 c_response  in  4; c_load_data  in  32; c_reset_done  in  1  cache side.
REQ-014 f_reset_done, d_reset_done  out  1  copies of c_reset_done.
REQ-015 grant_owner  out  2  NONE=0, FETCH=1, DATA=2; current port owner.

Function
REQ-016 States SHALL be ARB_IDLE, ARB_FETCH, ARB_DATA.
REQ-017 Arbitration point = ARB_IDLE, or any cycle c_response is DONE/ACCESSFAULT/MISSALIGNED/PAGEFAULT (terminal).
REQ-018 At arbitration point, winner chosen combinationally among requesters with cmd!=NONE; winner's cmd/address/types/store_data drive c_* in that same cycle (zero-cycle grant).
REQ-019 Winner selection: fixed priority DATA over FETCH unless REQ-030 applies.
REQ-020 Next state = ARB_FETCH/ARB_DATA per winner; ARB_IDLE if no request.
REQ-021 In ARB_FETCH/ARB_DATA, non-terminal cycles: owner's signals SHALL drive c_*; grant SHALL NOT change.
REQ-022 c_response and c_load_data SHALL route to owner in the same cycle, including the terminal cycle; winner of a terminal-cycle arbitration does not see that terminal response.
REQ-023 Non-owner with cmd!=NONE SHALL see WAIT; with cmd==NONE SHALL see IDLE; its load_data SHALL be 0.
REQ-024 With no owner and no winner: c_cmd=NONE, c_address=0, both responses IDLE.
REQ-025 Owner dropping cmd to NONE mid-transaction: arbiter keeps ownership until terminal response (no abort).
REQ-026 While c_reset_done=0: c_cmd=NONE, state held ARB_IDLE, both responses IDLE.
REQ-027 FLUSH_ALL treated as an ordinary transaction; terminal on DONE.

Reset
REQ-028 On rst_n=0: state ARB_IDLE, round-robin pointer = last-served FETCH (DATA wins next tie), c_cmd NONE, f_response/d_response IDLE, grant_owner 0.
REQ-029 Reset mid-transaction SHALL drop ownership; next cycle both requesters re-arbitrate.

Configuration
REQ-030 Macro COREVX_CACHE_ARB_ROUNDROBIN_EN: defined -> on tie, requester not served last wins; pointer updated on each grant; undefined -> fixed DATA priority, pointer logic absent.

Structure
REQ-031 corevx_cache_pkg SHALL hold cache cmd/response encodings, grant_owner encoding, and arbiter state enum.
REQ-032 Sub-module corevx_cache_arb_rr (2-way priority/round-robin picker) SHALL implement winner selection; rest is one module.

Verification
REQ-033 Fetch EXECUTE 0x2000 alone; cache WAIT x3 then DONE data 0x00000013 -> f_response DONE, f_load_data 0x13, grant_owner 1 then 0.
REQ-034 Simultaneous f_cmd EXECUTE 0x2004 and d_cmd LOAD 0x1000 (macro off) -> c_address 0x1000, f_response WAIT until data DONE, then c_address 0x2004 same cycle.
REQ-035 Macro on, both requesting continuously for 4 transactions -> grants alternate DATA, FETCH, DATA, FETCH.
REQ-036 Data STORE 0x1004 data 0xDEADBEEF gets PAGEFAULT -> d_response PAGEFAULT one cycle, c_store_data 0xDEADBEEF during ownership, ownership released.
REQ-037 rst_n low while ARB_DATA mid-WAIT -> next cycle grant_owner 0, responses IDLE; c_reset_done=0 holds c_cmd NONE.
REQ-038 Fetch FLUSH_ALL while data idle, then d_cmd LOAD arrives -> d_response WAIT until flush DONE, then load issued.
